mem_arbiter_rr: RTL and testbench

Parametrised N-port memory front end that replaces the ad-hoc dual-port memory model in the picorv32 + PCPI simulation wrapper. It arbitrates between the CPU port and any number of PCPI coprocessor ports round-robin onto one single-port, byte-writable RAM with configurable read latency. It also decodes the console and test-pass MMIO addresses and flags out-of-bounds accesses instead of stopping the simulation.

---
 rtl/mem_arb_pkg.sv | 28 ++
 rtl/rr_arbiter.sv | 26 ++
 rtl/mem_arbiter_rr.sv | 190 +++++++++++++++++++
 tb/tb_mem_arbiter_rr.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default MMIO constants for the round-robin memory front end.
// Imported by mem_arbiter_rr and by benches that inspect its debug state.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        CLS_RAM     = 2'd0,
        CLS_CONSOLE = 2'd1,
        CLS_PASS    = 2'd2,
        CLS_OOB     = 2'd3
    } addr_class_t;

    localparam logic [31:0] DEF_CONSOLE_ADDR = 32'h1000_0000;
    localparam logic [31:0] DEF_PASS_ADDR    = 32'h2000_0000;
    localparam logic [31:0] DEF_PASS_MAGIC   = 32'd123456789;

    // Index width that stays legal for a single-entry vector.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request strictly after 'last',
// wrapping around, so the previous winner is considered last.
module rr_arbiter #(
    parameter  int N  = 2,
    localparam int LW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [LW-1:0] last,
    output logic [LW-1:0] gnt_idx,
    output logic          any
);

    logic [LW-1:0] idx;

    // Scan farthest-first so the nearest requester after 'last' overwrites the rest.
    always_comb begin
        gnt_idx = '0;
        idx     = '0;
        for (int i = N; i >= 1; i--) begin
            idx = LW'((int'(last) + i) % N);
            if (req[idx]) gnt_idx = idx;
        end
        any = |req;
    end

endmodule

// File: rtl/mem_arbiter_rr.sv
// N-port round-robin front end onto one single-port byte-writable RAM, with
// console / test-pass MMIO decode and sticky out-of-bounds reporting.
module mem_arbiter_rr
    import mem_arb_pkg::*;
#(
    parameter  int          NUM_PORTS    = 2,
    parameter  int          ADDR_W       = 32,
    parameter  int          MEM_WORDS    = 3145728,
    parameter  int          READ_LAT     = 1,
    parameter  logic [31:0] CONSOLE_ADDR = DEF_CONSOLE_ADDR,
    parameter  logic [31:0] PASS_ADDR    = DEF_PASS_ADDR,
    parameter  logic [31:0] PASS_MAGIC   = DEF_PASS_MAGIC,
    localparam int          RA_W         = $clog2(MEM_WORDS),
    localparam int          PW           = idx_w(NUM_PORTS)
) (
    input  logic                        clk,
    input  logic                        resetn,
    // A master holds req_valid with stable fields until its req_ready bit pulses
    // for one cycle; the grant is taken in IDLE and then runs to completion even
    // if valid drops. Valid must drop or change in the cycle after ready.
    input  logic [NUM_PORTS-1:0]        req_valid,
    input  logic [4*NUM_PORTS-1:0]      req_wstrb,
    input  logic [ADDR_W*NUM_PORTS-1:0] req_addr,
    input  logic [32*NUM_PORTS-1:0]     req_wdata,
    output logic [NUM_PORTS-1:0]        req_ready,
    output logic [31:0]                 req_rdata,
    output logic                        ram_en,
    output logic [3:0]                  ram_we,
    output logic [RA_W-1:0]             ram_addr,
    output logic [31:0]                 ram_wdata,
    input  logic [31:0]                 ram_rdata,
    output logic                        console_valid,
    output logic [7:0]                  console_char,
    output logic                        tests_passed,
    output logic                        oob_err,
    output logic [ADDR_W-1:0]           oob_addr,
    output arb_state_t                  dbg_state
);

    localparam logic [ADDR_W:0] MEM_WORDS_W = (ADDR_W+1)'(MEM_WORDS);

    logic [ADDR_W-1:0] addr_arr  [NUM_PORTS];
    logic [3:0]        wstrb_arr [NUM_PORTS];
    logic [31:0]       wdata_arr [NUM_PORTS];

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        assign addr_arr[p]  = req_addr[p*ADDR_W +: ADDR_W];
        assign wstrb_arr[p] = req_wstrb[p*4 +: 4];
        assign wdata_arr[p] = req_wdata[p*32 +: 32];
    end

    arb_state_t        state, state_d;
    logic [PW-1:0]     last_grant, gnt_idx, grant_q;
    logic              any_req;
    logic [ADDR_W-1:0] addr_q, sel_addr;
    logic [3:0]        wstrb_q, sel_wstrb;
    logic [31:0]       wdata_q, sel_wdata;
    addr_class_t       cls_q, sel_cls;
    logic [1:0]        lat_cnt;

    logic                 ram_en_d, console_valid_d;
    logic [3:0]           ram_we_d;
    logic [RA_W-1:0]      ram_addr_d;
    logic [31:0]          ram_wdata_d, rdata_d;
    logic [7:0]           console_char_d;
    logic [NUM_PORTS-1:0] ready_d;

    rr_arbiter #(.N(NUM_PORTS)) u_rr_arbiter (
        .req     (req_valid),
        .last    (last_grant),
        .gnt_idx (gnt_idx),
        .any     (any_req)
    );

    function automatic addr_class_t classify(input logic [ADDR_W-1:0] a, input logic is_wr);
        if ({3'b000, a[ADDR_W-1:2]} < MEM_WORDS_W)          return CLS_RAM;
        else if (is_wr && a == ADDR_W'(CONSOLE_ADDR))       return CLS_CONSOLE;
        else if (is_wr && a == ADDR_W'(PASS_ADDR))          return CLS_PASS;
        else                                                return CLS_OOB;
    endfunction

    assign sel_addr  = addr_arr[gnt_idx];
    assign sel_wstrb = wstrb_arr[gnt_idx];
    assign sel_wdata = wdata_arr[gnt_idx];
    assign sel_cls   = classify(sel_addr, |sel_wstrb);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_d;
    end

    // RAM and console strobes are decided in IDLE so they appear registered in ACCESS.
    always_comb begin
        state_d         = state;
        ram_en_d        = 1'b0;
        ram_we_d        = 4'h0;
        ram_addr_d      = ram_addr;
        ram_wdata_d     = ram_wdata;
        console_valid_d = 1'b0;
        console_char_d  = console_char;
        ready_d         = '0;
        rdata_d         = req_rdata;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    state_d = ST_ACCESS;
                    if (sel_cls == CLS_RAM) begin
                        ram_en_d    = 1'b1;
                        ram_we_d    = sel_wstrb;
                        ram_addr_d  = sel_addr[RA_W+1:2];
                        ram_wdata_d = sel_wdata;
                    end
                    if (sel_cls == CLS_CONSOLE) begin
                        console_valid_d = 1'b1;
                        console_char_d  = sel_wdata[7:0];
                    end
                end
            end
            ST_ACCESS: begin
                if (cls_q == CLS_RAM && wstrb_q == 4'h0) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_RESP;
                    ready_d = NUM_PORTS'(1) << grant_q;
                    rdata_d = 32'h0;
                end
            end
            ST_WAIT: begin
                if (lat_cnt == 2'(READ_LAT - 1)) begin
                    state_d = ST_RESP;
                    ready_d = NUM_PORTS'(1) << grant_q;
                    rdata_d = ram_rdata;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            last_grant    <= PW'(NUM_PORTS - 1);
            grant_q       <= '0;
            addr_q        <= '0;
            wstrb_q       <= '0;
            wdata_q       <= '0;
            cls_q         <= CLS_RAM;
            lat_cnt       <= '0;
            ram_en        <= 1'b0;
            ram_we        <= '0;
            ram_addr      <= '0;
            ram_wdata     <= '0;
            console_valid <= 1'b0;
            console_char  <= '0;
            req_ready     <= '0;
            req_rdata     <= '0;
            tests_passed  <= 1'b0;
            oob_err       <= 1'b0;
            oob_addr      <= '0;
        end else begin
            ram_en        <= ram_en_d;
            ram_we        <= ram_we_d;
            ram_addr      <= ram_addr_d;
            ram_wdata     <= ram_wdata_d;
            console_valid <= console_valid_d;
            console_char  <= console_char_d;
            req_ready     <= ready_d;
            req_rdata     <= rdata_d;
            lat_cnt       <= (state == ST_WAIT) ? lat_cnt + 2'd1 : 2'd0;
            if (state == ST_IDLE && any_req) begin
                grant_q    <= gnt_idx;
                last_grant <= gnt_idx;
                addr_q     <= sel_addr;
                wstrb_q    <= sel_wstrb;
                wdata_q    <= sel_wdata;
                cls_q      <= sel_cls;
            end
            // Sticky flags: only the first out-of-bounds address is kept.
            if (state == ST_ACCESS) begin
                if (cls_q == CLS_PASS && wdata_q == PASS_MAGIC) tests_passed <= 1'b1;
                if (cls_q == CLS_OOB && !oob_err) begin
                    oob_err  <= 1'b1;
                    oob_addr <= addr_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Bench for mem_arbiter_rr: a 3-port READ_LAT=1 instance and a 2-port READ_LAT=2
// instance, each with a behavioural RAM and an expected-response queue.
module tb_mem_arbiter_rr;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Instance A: 3 ports, READ_LAT=1
    logic [2:0]  a_valid = '0, a_ready;
    logic [11:0] a_wstrb = '0;
    logic [95:0] a_addr = '0, a_wdata = '0;
    logic [31:0] a_rdata, a_ram_wdata, a_ram_rdata, a_oob_addr;
    logic        a_ram_en, a_console_valid, a_tests_passed, a_oob_err;
    logic [3:0]  a_ram_we;
    logic [9:0]  a_ram_addr;
    logic [7:0]  a_console_char;
    arb_state_t  a_state;
    logic [31:0] mem_a [0:1023];

    mem_arbiter_rr #(.NUM_PORTS(3), .ADDR_W(32), .MEM_WORDS(1024), .READ_LAT(1)) dut_a (
        .clk(clk), .resetn(resetn),
        .req_valid(a_valid), .req_wstrb(a_wstrb), .req_addr(a_addr), .req_wdata(a_wdata),
        .req_ready(a_ready), .req_rdata(a_rdata),
        .ram_en(a_ram_en), .ram_we(a_ram_we), .ram_addr(a_ram_addr),
        .ram_wdata(a_ram_wdata), .ram_rdata(a_ram_rdata),
        .console_valid(a_console_valid), .console_char(a_console_char),
        .tests_passed(a_tests_passed), .oob_err(a_oob_err), .oob_addr(a_oob_addr),
        .dbg_state(a_state)
    );

    always @(posedge clk) begin
        if (a_ram_en) begin
            for (int b = 0; b < 4; b++)
                if (a_ram_we[b]) mem_a[a_ram_addr][b*8 +: 8] <= a_ram_wdata[b*8 +: 8];
            a_ram_rdata <= mem_a[a_ram_addr];
        end
    end

    // Instance B: 2 ports, READ_LAT=2
    logic [1:0]  b_valid = '0, b_ready;
    logic [7:0]  b_wstrb = '0;
    logic [63:0] b_addr = '0, b_wdata = '0;
    logic [31:0] b_rdata, b_ram_wdata, b_ram_rdata, b_rd1, b_oob_addr;
    logic        b_ram_en, b_console_valid, b_tests_passed, b_oob_err;
    logic [3:0]  b_ram_we;
    logic [9:0]  b_ram_addr;
    logic [7:0]  b_console_char;
    arb_state_t  b_state;
    logic [31:0] mem_b [0:1023];

    mem_arbiter_rr #(.NUM_PORTS(2), .ADDR_W(32), .MEM_WORDS(1024), .READ_LAT(2)) dut_b (
        .clk(clk), .resetn(resetn),
        .req_valid(b_valid), .req_wstrb(b_wstrb), .req_addr(b_addr), .req_wdata(b_wdata),
        .req_ready(b_ready), .req_rdata(b_rdata),
        .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_addr(b_ram_addr),
        .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata),
        .console_valid(b_console_valid), .console_char(b_console_char),
        .tests_passed(b_tests_passed), .oob_err(b_oob_err), .oob_addr(b_oob_addr),
        .dbg_state(b_state)
    );

    always @(posedge clk) begin
        if (b_ram_en) begin
            for (int b = 0; b < 4; b++)
                if (b_ram_we[b]) mem_b[b_ram_addr][b*8 +: 8] <= b_ram_wdata[b*8 +: 8];
            b_rd1 <= mem_b[b_ram_addr];
        end
        b_ram_rdata <= b_rd1;
    end

    // Scoreboards: {port[1:0], rdata[31:0]}
    logic [33:0] exp_q[$];
    logic [33:0] b_exp_q[$];

    always @(negedge clk) begin
        logic [33:0] e;
        if (resetn && a_ready != 3'b000) begin
            if (exp_q.size() == 0) check("a_unexpected_ready", 64'(a_ready), 64'd0);
            else begin
                e = exp_q.pop_front();
                check("a_ready_port", 64'(a_ready), 64'(3'b001 << e[33:32]));
                check("a_rdata", 64'(a_rdata), 64'(e[31:0]));
            end
        end
        if (resetn && b_ready != 2'b00) begin
            if (b_exp_q.size() == 0) check("b_unexpected_ready", 64'(b_ready), 64'd0);
            else begin
                e = b_exp_q.pop_front();
                check("b_ready_port", 64'(b_ready), 64'(2'b01 << e[33:32]));
                check("b_rdata", 64'(b_rdata), 64'(e[31:0]));
            end
        end
    end

    // Single transaction on A; called just after a posedge with the DUT in IDLE.
    task automatic a_xact(input int port, input logic [31:0] addr, input logic [3:0] wstrb,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata,
                          input int exp_lat, input bit is_ram, input bit is_con);
        int cyc = 0;
        bit done = 0;
        exp_q.push_back({2'(port), exp_rdata});
        a_valid[port] = 1'b1;
        a_addr[port*32 +: 32]  = addr;
        a_wstrb[port*4 +: 4]   = wstrb;
        a_wdata[port*32 +: 32] = wdata;
        while (!done && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) begin
                check("a_ram_en", 64'(a_ram_en), 64'(is_ram));
                check("a_console_valid", 64'(a_console_valid), 64'(is_con));
                if (is_ram) begin
                    check("a_ram_we", 64'(a_ram_we), 64'(wstrb));
                    check("a_ram_addr", 64'(a_ram_addr), 64'(addr[11:2]));
                end
                if (is_con) check("a_console_char", 64'(a_console_char), 64'(wdata[7:0]));
            end
            if (a_ready[port]) done = 1;
        end
        check("a_latency", 64'(cyc), 64'(exp_lat));
        a_valid[port] = 1'b0;
        a_wstrb[port*4 +: 4] = 4'h0;
        @(posedge clk); #1;
    endtask

    task automatic b_xact(input int port, input logic [31:0] addr, input logic [3:0] wstrb,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata, input int exp_lat);
        int cyc = 0;
        bit done = 0;
        b_exp_q.push_back({2'(port), exp_rdata});
        b_valid[port] = 1'b1;
        b_addr[port*32 +: 32]  = addr;
        b_wstrb[port*4 +: 4]   = wstrb;
        b_wdata[port*32 +: 32] = wdata;
        while (!done && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            if (b_ready[port]) done = 1;
        end
        check("b_latency", 64'(cyc), 64'(exp_lat));
        b_valid[port] = 1'b0;
        b_wstrb[port*4 +: 4] = 4'h0;
        @(posedge clk); #1;
    endtask

    // All A ports request writes together; count n ready pulses, then release.
    task automatic a_all_request(input int n);
        int got = 0;
        int cyc = 0;
        for (int p = 0; p < 3; p++) begin
            a_valid[p] = 1'b1;
            a_addr[p*32 +: 32]  = 32'h300 + 32'(p*4);
            a_wstrb[p*4 +: 4]   = 4'hF;
            a_wdata[p*32 +: 32] = 32'(p);
        end
        while (got < n && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (a_ready != 3'b000) got++;
        end
        check("a_grant_count", 64'(got), 64'(n));
        a_valid = '0;
        a_wstrb = '0;
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 64'(a_ready), 64'd0);
        check("rst_rdata", 64'(a_rdata), 64'd0);
        check("rst_ram_en", 64'(a_ram_en), 64'd0);
        check("rst_ram_we", 64'(a_ram_we), 64'd0);
        check("rst_ram_addr", 64'(a_ram_addr), 64'd0);
        check("rst_ram_wdata", 64'(a_ram_wdata), 64'd0);
        check("rst_console", 64'({a_console_valid, a_console_char}), 64'd0);
        check("rst_flags", 64'({a_tests_passed, a_oob_err}), 64'd0);
        check("rst_oob_addr", 64'(a_oob_addr), 64'd0);
        check("rst_state", 64'(a_state), 64'(ST_IDLE));
        check("rst_b_ready", 64'(b_ready), 64'd0);
        resetn = 1'b1;
        @(posedge clk); #1;

        // Fairness: 0,1,2,0,1,2 then a lone port 2 wins immediately
        for (int k = 0; k < 6; k++) exp_q.push_back({2'(k % 3), 32'h0});
        a_all_request(6);
        a_xact(2, 32'h310, 4'hF, 32'h22, 32'h0, 2, 1, 0);

        // Write then read, byte strobe merge
        a_xact(0, 32'h100, 4'hF, 32'hDEADBEEF, 32'h0, 2, 1, 0);
        a_xact(0, 32'h100, 4'h0, 32'h0, 32'hDEADBEEF, 3, 1, 0);
        a_xact(1, 32'h200, 4'hF, 32'h11223344, 32'h0, 2, 1, 0);
        a_xact(0, 32'h200, 4'b0001, 32'h000000AA, 32'h0, 2, 1, 0);
        a_xact(1, 32'h200, 4'h0, 32'h0, 32'h112233AA, 3, 1, 0);
        a_xact(2, 32'h310, 4'h0, 32'h0, 32'h22, 3, 1, 0);

        // MMIO
        a_xact(0, 32'h1000_0000, 4'hF, 32'h41, 32'h0, 2, 0, 1);
        a_xact(0, 32'h2000_0000, 4'hF, 32'd7, 32'h0, 2, 0, 0);
        check("pass_wrong_magic", 64'(a_tests_passed), 64'd0);
        a_xact(1, 32'h2000_0000, 4'hF, 32'd123456789, 32'h0, 2, 0, 0);
        check("pass_magic", 64'(a_tests_passed), 64'd1);
        a_xact(0, 32'h2000_0000, 4'hF, 32'd5, 32'h0, 2, 0, 0);
        check("pass_sticky", 64'(a_tests_passed), 64'd1);
        check("mmio_no_oob", 64'(a_oob_err), 64'd0);

        // Out of bounds, including a read of the console address
        a_xact(0, 32'h3000_0000, 4'h0, 32'h0, 32'h0, 2, 0, 0);
        check("oob_err", 64'(a_oob_err), 64'd1);
        check("oob_addr", 64'(a_oob_addr), 64'h3000_0000);
        a_xact(1, 32'h4000_0000, 4'hF, 32'h1234, 32'h0, 2, 0, 0);
        a_xact(0, 32'h1000_0000, 4'h0, 32'h0, 32'h0, 2, 0, 0);
        check("oob_addr_first_kept", 64'(a_oob_addr), 64'h3000_0000);

        // READ_LAT=2 instance
        b_xact(1, 32'h80, 4'hF, 32'hCAFEF00D, 32'h0, 2);
        b_xact(0, 32'h80, 4'h0, 32'h0, 32'hCAFEF00D, 4);
        b_xact(1, 32'h80, 4'b0010, 32'h0000_5500, 32'h0, 2);
        b_xact(1, 32'h80, 4'h0, 32'h0, 32'hCAFE550D, 4);

        // Reset while port 1 read sits in WAIT
        a_valid[1] = 1'b1;
        a_addr[32 +: 32] = 32'h100;
        a_wstrb[4 +: 4]  = 4'h0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("wait_before_reset", 64'(a_state), 64'(ST_WAIT));
        resetn = 1'b0;
        a_valid = '0;
        @(posedge clk); #1;
        check("abort_no_ready", 64'(a_ready), 64'd0);
        check("abort_state", 64'(a_state), 64'(ST_IDLE));
        @(posedge clk); #1;
        resetn = 1'b1;
        check("abort_flags", 64'({a_tests_passed, a_oob_err}), 64'd0);
        check("abort_oob_addr", 64'(a_oob_addr), 64'd0);
        exp_q.push_back({2'd0, 32'h0});
        a_all_request(1);

        repeat (3) @(posedge clk);
        #1;
        check("a_queue_drained", 64'(exp_q.size()), 64'd0);
        check("b_queue_drained", 64'(b_exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
